// File: rtl/udp_tx_framer_if.sv
// Byte-stream handshake bundle shared by the payload input and the frame output
// of udp_tx_framer.
//   data  : 8-bit byte
//   valid : byte valid (driven by master)
//   last  : final byte of a packet/frame (driven by master)
//   ready : sink accepts the byte (driven by slave)
// A byte transfers on a clock edge where valid && ready.
interface udp_tx_framer_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/udp_tx_framer.sv
// udp_tx_framer
// Builds an Ethernet/IPv4/UDP frame as a byte stream for the MAC transmitter.
// A send request carries the payload length.
// The framer then spends ten cycles summing the IPv4 header words to get the header checksum.
// It then emits 42 header bytes, passes the payload through, and zero-pads up to the 60-byte minimum frame.
// The MAC appends the FCS.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   src_mac, dst_mac    [47:0] Ethernet addresses (sampled on request accept)
//   src_ip, dst_ip      [31:0] IPv4 addresses (sampled on request accept)
//   src_port, dst_port  [15:0] UDP ports (sampled on request accept)
//   req_valid, req_len, req_ready  send request (len in bytes, 0..MAX_PAYLOAD)
//   s   (slave)   payload byte stream in
//   m   (master)  frame byte stream out; m.last marks the final frame byte
//   len_err  one-cycle pulse: payload s.last disagrees with req_len
//   req_err  one-cycle pulse: req_len above MAX_PAYLOAD, request dropped
module udp_tx_framer #(
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter logic [7:0]  TTL         = 8'd64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [47:0]            src_mac,
    input  logic [47:0]            dst_mac,
    input  logic [31:0]            src_ip,
    input  logic [31:0]            dst_ip,
    input  logic [15:0]            src_port,
    input  logic [15:0]            dst_port,
    input  logic                   req_valid,
    input  logic [10:0]            req_len,
    output logic                   req_ready,
    udp_tx_framer_if.slave         s,
    udp_tx_framer_if.master        m,
    output logic                   len_err,
    output logic                   req_err
);

    localparam logic [11:0] MAX_LEN  = 12'(MAX_PAYLOAD);
    localparam logic [10:0] HDR_LAST = 11'd41;
    localparam logic [10:0] CSUM_LAST = 11'd9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CSUM    = 3'd1,
        HDR     = 3'd2,
        PAYLOAD = 3'd3,
        PAD     = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic [15:0] ip_id;

    // Request snapshot
    logic [47:0] src_mac_q, dst_mac_q;
    logic [31:0] src_ip_q, dst_ip_q;
    logic [15:0] src_port_q, dst_port_q;
    logic [10:0] len_q;

    logic [19:0] acc;
    logic [15:0] ip_csum;

    logic        accept;
    logic        req_err_set;
    logic        frame_done;
    logic        pay_xfer;
    logic        len_err_set;

    logic [15:0] ip_total;
    logic [15:0] udp_len;
    logic [10:0] len_last;
    logic [10:0] pad_last;
    logic        len_small;
    logic [15:0] csum_w;
    logic [7:0]  hdr_byte;

    // Fold the carry nibble back into the low word twice, then take the ones' complement.
    // Ten 16-bit words cannot exceed 20 bits.
    // After the first fold, at most one carry remains.
    function automatic logic [15:0] csum_fold(input logic [19:0] sum);
        logic [16:0] f1;
        logic [15:0] f2;
        f1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
        f2 = f1[15:0] + {15'b0, f1[16]};
        return ~f2;
    endfunction

    assign ip_total  = 16'd28 + {5'b0, len_q};
    assign udp_len   = 16'd8 + {5'b0, len_q};
    assign len_last  = len_q - 11'd1;
    assign len_small = (len_q < 11'd18);
    // Only meaningful when len_small; pad byte count is 18 - len.
    assign pad_last  = 11'd17 - len_q;

    // IPv4 header words in transmit order, checksum word taken as zero.
    always_comb begin
        csum_w = 16'h0000;
        case (cnt[3:0])
            4'd0: csum_w = 16'h4500;
            4'd1: csum_w = ip_total;
            4'd2: csum_w = ip_id;
            4'd3: csum_w = 16'h4000;
            4'd4: csum_w = {TTL, 8'h11};
            4'd5: csum_w = 16'h0000;
            4'd6: csum_w = src_ip_q[31:16];
            4'd7: csum_w = src_ip_q[15:0];
            4'd8: csum_w = dst_ip_q[31:16];
            4'd9: csum_w = dst_ip_q[15:0];
            default: csum_w = 16'h0000;
        endcase
    end

    // Header byte for the current header index; all fields big-endian.
    always_comb begin
        hdr_byte = 8'h00;
        case (cnt[5:0])
            6'd0:  hdr_byte = dst_mac_q[47:40];
            6'd1:  hdr_byte = dst_mac_q[39:32];
            6'd2:  hdr_byte = dst_mac_q[31:24];
            6'd3:  hdr_byte = dst_mac_q[23:16];
            6'd4:  hdr_byte = dst_mac_q[15:8];
            6'd5:  hdr_byte = dst_mac_q[7:0];
            6'd6:  hdr_byte = src_mac_q[47:40];
            6'd7:  hdr_byte = src_mac_q[39:32];
            6'd8:  hdr_byte = src_mac_q[31:24];
            6'd9:  hdr_byte = src_mac_q[23:16];
            6'd10: hdr_byte = src_mac_q[15:8];
            6'd11: hdr_byte = src_mac_q[7:0];
            6'd12: hdr_byte = 8'h08;
            6'd13: hdr_byte = 8'h00;
            6'd14: hdr_byte = 8'h45;
            6'd15: hdr_byte = 8'h00;
            6'd16: hdr_byte = ip_total[15:8];
            6'd17: hdr_byte = ip_total[7:0];
            6'd18: hdr_byte = ip_id[15:8];
            6'd19: hdr_byte = ip_id[7:0];
            6'd20: hdr_byte = 8'h40;
            6'd21: hdr_byte = 8'h00;
            6'd22: hdr_byte = TTL;
            6'd23: hdr_byte = 8'h11;
            6'd24: hdr_byte = ip_csum[15:8];
            6'd25: hdr_byte = ip_csum[7:0];
            6'd26: hdr_byte = src_ip_q[31:24];
            6'd27: hdr_byte = src_ip_q[23:16];
            6'd28: hdr_byte = src_ip_q[15:8];
            6'd29: hdr_byte = src_ip_q[7:0];
            6'd30: hdr_byte = dst_ip_q[31:24];
            6'd31: hdr_byte = dst_ip_q[23:16];
            6'd32: hdr_byte = dst_ip_q[15:8];
            6'd33: hdr_byte = dst_ip_q[7:0];
            6'd34: hdr_byte = src_port_q[15:8];
            6'd35: hdr_byte = src_port_q[7:0];
            6'd36: hdr_byte = dst_port_q[15:8];
            6'd37: hdr_byte = dst_port_q[7:0];
            6'd38: hdr_byte = udp_len[15:8];
            6'd39: hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Next-state and stream outputs
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        req_ready   = 1'b0;
        s.ready     = 1'b0;
        m.valid     = 1'b0;
        m.last      = 1'b0;
        m.data      = 8'h00;
        accept      = 1'b0;
        req_err_set = 1'b0;
        frame_done  = 1'b0;
        pay_xfer    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if ({1'b0, req_len} > MAX_LEN) begin
                        req_err_set = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = CSUM;
                        cnt_nxt   = 11'd0;
                    end
                end
            end
            CSUM: begin
                if (cnt == CSUM_LAST) begin
                    state_nxt = HDR;
                    cnt_nxt   = 11'd0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            HDR: begin
                m.valid = 1'b1;
                m.data  = hdr_byte;
                if (m.ready) begin
                    if (cnt == HDR_LAST) begin
                        cnt_nxt   = 11'd0;
                        state_nxt = (len_q == 11'd0) ? PAD : PAYLOAD;
                    end else begin
                        cnt_nxt = cnt + 11'd1;
                    end
                end
            end
            PAYLOAD: begin
                // Straight pass-through; the source sees the sink's ready directly.
                m.data  = s.data;
                m.valid = s.valid;
                s.ready = m.ready;
                m.last  = (cnt == len_last) && !len_small;
                if (s.valid && m.ready) begin
                    pay_xfer = 1'b1;
                    if (cnt == len_last) begin
                        cnt_nxt    = 11'd0;
                        state_nxt  = len_small ? PAD : IDLE;
                        frame_done = !len_small;
                    end else begin
                        cnt_nxt = cnt + 11'd1;
                    end
                end
            end
            PAD: begin
                m.valid = 1'b1;
                m.last  = (cnt == pad_last);
                if (m.ready) begin
                    if (cnt == pad_last) begin
                        cnt_nxt    = 11'd0;
                        state_nxt  = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 11'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 11'd0;
            end
        endcase
    end

    // A length error is raised per payload byte.
    // It fires when s.last is set on a byte other than the final counted one,
    // or when s.last is clear on the final counted byte.
    assign len_err_set = pay_xfer && (s.last != (cnt == len_last));

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 11'd0;
            ip_id   <= 16'h0000;
            len_err <= 1'b0;
            req_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            len_err <= len_err_set;
            req_err <= req_err_set;
            if (frame_done) begin
                ip_id <= ip_id + 16'd1;
            end
        end
    end

    // Request snapshot and checksum datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            src_mac_q  <= src_mac;
            dst_mac_q  <= dst_mac;
            src_ip_q   <= src_ip;
            dst_ip_q   <= dst_ip;
            src_port_q <= src_port;
            dst_port_q <= dst_port;
            len_q      <= req_len;
            acc        <= 20'd0;
        end else if (state == CSUM) begin
            acc <= acc + {4'b0, csum_w};
            if (cnt == CSUM_LAST) begin
                ip_csum <= csum_fold(acc + {4'b0, csum_w});
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer.
// A table of frames is checked first.
// Each table entry gives the request, the expected header fields, the frame length and the len_err count.
// Hand-written sequences follow for the oversize request and for reset in mid-header.
module tb_udp_tx_framer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [47:0] src_mac, dst_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port;
    logic        req_valid;
    logic [10:0] req_len;
    logic        req_ready;
    logic        len_err, req_err;

    udp_tx_framer_if s_if ();
    udp_tx_framer_if m_if ();

    udp_tx_framer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_mac   (src_mac),
        .dst_mac   (dst_mac),
        .src_ip    (src_ip),
        .dst_ip    (dst_ip),
        .src_port  (src_port),
        .dst_port  (dst_port),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .s         (s_if),
        .m         (m_if),
        .len_err   (len_err),
        .req_err   (req_err)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [7:0] pl   [0:2047];
    logic [7:0] got  [0:2047];
    logic [7:0] expb [0:2047];

    typedef struct {
        int          len;
        int          slast;   // 1-based payload byte carrying s_last (0 = none)
        bit          stall;
        logic [15:0] tl;      // IPv4 total length
        logic [15:0] id;
        logic [15:0] csum;
        int          flen;
        int          lerr;    // expected len_err pulses
    } vec_t;

    vec_t vecs [0:6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_fields();
        src_mac  = 48'h02_00_00_00_00_01;
        dst_mac  = 48'h02_11_22_33_44_55;
        src_ip   = 32'hC0A8_0001;
        dst_ip   = 32'hC0A8_00C7;
        src_port = 16'h04D2;
        dst_port = 16'h162E;
    endtask

    task automatic build_expected(input vec_t v);
        logic [15:0] ul;
        ul = 16'(8 + v.len);
        for (int k = 0; k < 6; k++) begin
            expb[k]     = dst_mac[47 - 8*k -: 8];
            expb[6 + k] = src_mac[47 - 8*k -: 8];
        end
        expb[12] = 8'h08; expb[13] = 8'h00; expb[14] = 8'h45; expb[15] = 8'h00;
        expb[16] = v.tl[15:8]; expb[17] = v.tl[7:0];
        expb[18] = v.id[15:8]; expb[19] = v.id[7:0];
        expb[20] = 8'h40; expb[21] = 8'h00; expb[22] = 8'd64; expb[23] = 8'h11;
        expb[24] = v.csum[15:8]; expb[25] = v.csum[7:0];
        for (int k = 0; k < 4; k++) begin
            expb[26 + k] = src_ip[31 - 8*k -: 8];
            expb[30 + k] = dst_ip[31 - 8*k -: 8];
        end
        expb[34] = src_port[15:8]; expb[35] = src_port[7:0];
        expb[36] = dst_port[15:8]; expb[37] = dst_port[7:0];
        expb[38] = ul[15:8]; expb[39] = ul[7:0];
        expb[40] = 8'h00; expb[41] = 8'h00;
        for (int k = 0; k < v.len; k++) expb[42 + k] = pl[k];
        for (int k = 42 + v.len; k < v.flen; k++) expb[k] = 8'h00;
    endtask

    task automatic run_frame(input vec_t v, input int row, output int first_cyc, output int last_cyc);
        int idx, nb, cyc, lerr_cnt, mism, first_bad;
        bit done, sready_seen, stall_bad, prev_stall;
        logic [7:0] prev_data;
        logic prev_last;
        for (int i = 0; i < v.len; i++) pl[i] = 8'(i * 7 + row * 13 + 3);
        build_expected(v);
        first_cyc = 0; last_cyc = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_len   = 11'(v.len);
        #1 check($sformatf("req_ready_idle[%0d]", row), {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        // Change everything after acceptance; the frame must use the snapshot.
        req_valid = 1'b0;
        req_len   = 11'h7FF;
        src_port  = 16'hDEAD;
        dst_ip    = 32'h0;
        src_mac   = 48'h0;
        idx = 0; nb = 0; cyc = 0; lerr_cnt = 0;
        done = 0; sready_seen = 0; stall_bad = 0; prev_stall = 0;
        prev_data = 8'h00; prev_last = 1'b0;
        while (!done && cyc < 6000) begin
            m_if.ready = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (idx < v.len && (!v.stall || $urandom_range(0, 3) != 0)) begin
                s_if.valid = 1'b1;
                s_if.data  = pl[idx];
                s_if.last  = (idx + 1 == v.slast);
            end else begin
                s_if.valid = 1'b0;
                s_if.data  = 8'h00;
                s_if.last  = 1'b0;
            end
            #1;
            if (len_err) lerr_cnt++;
            if (s_if.ready) sready_seen = 1;
            if (prev_stall && m_if.valid && (m_if.data !== prev_data || m_if.last !== prev_last))
                stall_bad = 1;
            prev_stall = m_if.valid && !m_if.ready;
            prev_data  = m_if.data;
            prev_last  = m_if.last;
            if (m_if.valid && m_if.ready) begin
                if (nb == 0) first_cyc = cycle;
                if (nb < 2048) got[nb] = m_if.data;
                nb++;
                if (m_if.last) begin
                    done = 1;
                    last_cyc = cycle;
                end
            end
            if (s_if.valid && s_if.ready) idx++;
            @(negedge clk);
            cyc++;
        end
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b1;
        #1 if (len_err) lerr_cnt++;
        set_fields();
        check($sformatf("frame_done[%0d]", row), {31'b0, done}, 32'd1);
        check($sformatf("frame_len[%0d]", row), nb, v.flen);
        check($sformatf("ip_total_len[%0d]", row), {16'b0, got[16], got[17]}, {16'b0, v.tl});
        check($sformatf("ip_id[%0d]", row), {16'b0, got[18], got[19]}, {16'b0, v.id});
        check($sformatf("ip_csum[%0d]", row), {16'b0, got[24], got[25]}, {16'b0, v.csum});
        mism = 0; first_bad = -1;
        for (int i = 0; i < nb && i < v.flen && i < 2048; i++) begin
            if (got[i] !== expb[i]) begin
                if (first_bad < 0) first_bad = i;
                mism++;
            end
        end
        if (mism != 0)
            $display("  row %0d first bad byte %0d got 0x%0h want 0x%0h", row, first_bad,
                     got[first_bad], expb[first_bad]);
        check($sformatf("frame_bytes_bad[%0d]", row), mism, 0);
        check($sformatf("payload_consumed[%0d]", row), idx, v.len);
        check($sformatf("len_err_pulses[%0d]", row), lerr_cnt, v.lerr);
        check($sformatf("stall_stable[%0d]", row), {31'b0, stall_bad}, 32'd0);
        if (v.len == 0)
            check($sformatf("s_ready_never[%0d]", row), {31'b0, sready_seen}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_c, last_c, prev_last_c;
        bit mv;
        //            len  slast stall tl        id     csum      flen  lerr
        vecs[0] = '{  87,  87,   0, 16'h0073, 16'd0, 16'hB861, 129,  0};
        vecs[1] = '{   0,   0,   0, 16'h001C, 16'd1, 16'hB8B7,  60,  0};
        vecs[2] = '{  18,  18,   1, 16'h002E, 16'd2, 16'hB8A4,  60,  0};
        vecs[3] = '{1472, 1472,  1, 16'h05DC, 16'd3, 16'hB2F5, 1514, 0};
        vecs[4] = '{  17,  17,   0, 16'h002D, 16'd4, 16'hB8A3,  60,  0};
        vecs[5] = '{   1,   1,   1, 16'h001D, 16'd5, 16'hB8B2,  60,  0};
        vecs[6] = '{  10,   5,   0, 16'h0026, 16'd6, 16'hB8A8,  60,  2};

        set_fields();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_len = 11'd0;
        s_if.valid = 1'b0;
        s_if.data = 8'h00;
        s_if.last = 1'b0;
        m_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_s_ready",   {31'b0, s_if.ready}, 32'd0);
        check("rst_m_valid",   {31'b0, m_if.valid}, 32'd0);
        check("rst_m_last",    {31'b0, m_if.last}, 32'd0);
        check("rst_m_data",    {24'b0, m_if.data}, 32'd0);
        check("rst_len_err",   {31'b0, len_err}, 32'd0);
        check("rst_req_err",   {31'b0, req_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        prev_last_c = 0;
        for (int r = 0; r < 7; r++) begin
            run_frame(vecs[r], r, first_c, last_c);
            if (r > 0)
                check($sformatf("ifg_at_least_11[%0d]", r), {31'b0, (first_c - prev_last_c) >= 11}, 32'd1);
            prev_last_c = last_c;
        end

        // Oversize request: dropped with a single req_err pulse.
        @(negedge clk);
        req_valid = 1'b1;
        req_len   = 11'd1473;
        @(negedge clk);
        req_valid = 1'b0;
        req_len   = 11'd0;
        #1;
        check("req_err_pulse", {31'b0, req_err}, 32'd1);
        check("req_err_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        #1 check("req_err_single", {31'b0, req_err}, 32'd0);
        mv = 0;
        repeat (20) begin
            @(negedge clk);
            #1 if (m_if.valid) mv = 1;
        end
        check("req_err_no_frame", {31'b0, mv}, 32'd0);
        check("req_err_stay_idle", {31'b0, req_ready}, 32'd1);

        // Reset in the middle of the header aborts the frame and clears ip_id.
        @(negedge clk);
        req_valid = 1'b1;
        req_len   = 11'd87;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (14) @(negedge clk);
        #1 check("hdr_active_before_rst", {31'b0, m_if.valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid",   {31'b0, m_if.valid}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_s_ready",   {31'b0, s_if.ready}, 32'd0);
        check("midrst_m_data",    {24'b0, m_if.data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(vecs[0], 7, first_c, last_c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
